// File: rtl/bus_timer_pkg.sv
// bus_timer shared definitions.
// Register offsets, CTRL/STATUS bit positions and prescaler width.
package bus_timer_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DIV    = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_PRESC  = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IEN  = 1;
  localparam int CTRL_AUTO = 2;
  localparam int CTRL_W    = 3;

  localparam int STAT_EXP  = 0;

  localparam int PRESC_W   = 8;

endpackage

// File: rtl/bus_timer_prescaler.sv
// bus_timer prescaler: one tick every presc+1 clocks.
// Phase restarts at 0 whenever the divisor register is rewritten.
module bus_timer_prescaler
  import bus_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] phase_q;
  logic [PRESC_W-1:0] phase_d;

  assign tick = (phase_q == presc);

  // Next phase: wrap on tick, force to 0 on restart.
  always_comb begin
    phase_d = tick ? '0 : phase_q + PRESC_W'(1);
    if (restart) phase_d = '0;
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: bus-mapped down-counter with expiry flag and interrupt.
// Optional prescaler enabled by defining BUS_TIMER_PRESCALE_EN.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_din,
  output logic [31:0] bus_dout,
  output logic        bus_ack,
  output logic        bus_irq
);

  logic                 ack_q;
  logic [31:0]          dout_q, dout_d;
  logic [31:0]          rdata;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 exp_q, exp_d;
  logic                 start, wr;
  logic                 wr_ctrl, wr_div, wr_cnt, wr_stat;
  logic                 tick, expire;
  logic [PRESC_W-1:0]   presc_rd;

  assign start   = bus_stb & ~ack_q;
  assign wr      = start & bus_we;
  assign wr_ctrl = wr & (bus_addr == ADDR_CTRL);
  assign wr_div  = wr & (bus_addr == ADDR_DIV);
  assign wr_cnt  = wr & (bus_addr == ADDR_COUNT);
  assign wr_stat = wr & (bus_addr == ADDR_STATUS);

`ifdef BUS_TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic               wr_presc;

  assign wr_presc = wr & (bus_addr == ADDR_PRESC);
  assign presc_rd = presc_q;

  // Prescaler divisor register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           presc_q <= '0;
    else if (wr_presc) presc_q <= bus_din[PRESC_W-1:0];
  end

  bus_timer_prescaler u_presc (
    .clk     (clk),
    .rst     (rst),
    .presc   (presc_q),
    .restart (wr_presc),
    .tick    (tick)
  );
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif

  assign expire  = tick & ctrl_q[CTRL_EN] & (cnt_q == '0);
  assign bus_irq = exp_q & ctrl_q[CTRL_IEN];
  assign bus_ack = ack_q;
  assign bus_dout = dout_q;

  // Read mux; sampled at the access start edge, shown during ack.
  always_comb begin
    rdata = '0;
    case (bus_addr)
      ADDR_CTRL:   rdata = 32'(ctrl_q);
      ADDR_DIV:    rdata = 32'(div_q);
      ADDR_COUNT:  rdata = 32'(cnt_q);
      ADDR_STATUS: rdata = 32'(exp_q);
      ADDR_PRESC:  rdata = 32'(presc_rd);
      default:     rdata = '0;
    endcase
    dout_d = (start & ~bus_we) ? rdata : '0;
  end

  // Counter update first, then bus writes override it.
  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (tick & ctrl_q[CTRL_EN]) begin
      if (cnt_q != '0)          cnt_d = cnt_q - CNT_WIDTH'(1);
      else if (ctrl_q[CTRL_AUTO]) cnt_d = div_q;
      else                      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr_ctrl) ctrl_d = bus_din[CTRL_W-1:0];
    if (wr_div)  div_d  = bus_din[CNT_WIDTH-1:0];
    if (wr_cnt)  cnt_d  = bus_din[CNT_WIDTH-1:0];
    exp_d = expire | (exp_q & ~(wr_stat & bus_din[STAT_EXP]));
  end

  // Register state and bus handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      dout_q <= '0;
      ctrl_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      exp_q  <= 1'b0;
    end else begin
      ack_q  <= start;
      dout_q <= dout_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      exp_q  <= exp_d;
    end
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter CNT_WIDTH, default 32, SHALL set the counter/divisor width (legal range 8..32).
REQ-002 clk  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-003 rst  in  1  system reset; asynchronous, active-high.
REQ-004 bus_stb  in  1  bus strobe from the initiator.
REQ-005 bus_we  in  1  write enable; 1 = write, 0 = read.
REQ-006 bus_addr  in  3  word offset, bits [4:2] of the byte address.
REQ-007 bus_din  in  32  write data from the initiator.
REQ-008 bus_dout  out  32  read data to the initiator.
REQ-009 bus_ack  out  1  access acknowledge.
REQ-010 bus_irq  out  1  interrupt request; drives one line of the CPU's bus_irq[15:0].

Function
REQ-011 Register map: 0 CTRL (bit0 EN, bit1 IEN, bit2 AUTO); 1 DIV; 2 COUNT; 3 STATUS (bit0 EXP); 4 PRESC[7:0]; 5..7 reserved.
REQ-012 Access start: any cycle with bus_stb=1 and bus_ack=0.
- bus_ack SHALL be 1 in the following cycle, for exactly one cycle (one wait state).
- bus_ack SHALL then be 0 for at least one cycle, even if bus_stb stays high.
REQ-013 Write commit: registered at the clock edge that raises bus_ack.
REQ-014 Read data: bus_dout valid while bus_ack=1; 0 otherwise.
- Bits above CNT_WIDTH (DIV/COUNT) and unused CTRL/STATUS/PRESC bits read 0.
- Reserved offsets read 0; writes to them are ignored.
REQ-015 Tick: every clock when PRESC=0; otherwise one cycle in every PRESC+1 cycles.
REQ-016 On a tick with EN=1 and COUNT!=0: COUNT decrements by 1.
REQ-017 On a tick with EN=1 and COUNT=0: EXP SHALL set.
- AUTO=1: COUNT reloads from DIV.
- AUTO=0: EN clears and COUNT holds 0.
REQ-018 Expiry period with PRESC=0 and AUTO=1 SHALL be DIV+1 clocks.
REQ-019 Writing CTRL SHALL NOT load COUNT.
REQ-020 A COUNT write SHALL override a same-cycle decrement or reload.
REQ-021 Writing STATUS bit0=1 clears EXP; a same-cycle expiry wins (EXP stays 1).
REQ-022 A CTRL write clearing EN in the same cycle as an expiry: write wins for EN; EXP still sets.
REQ-023 bus_irq SHALL equal EXP AND IEN, driven from registers (no combinational path from bus inputs).
REQ-024 The prescaler phase counter SHALL restart at 0 whenever PRESC is written.

Reset
REQ-025 While rst=1, all registers SHALL be held at their reset values: CTRL, DIV, COUNT, EXP, PRESC, prescaler phase all 0.
REQ-026 While rst=1: bus_ack=0, bus_dout=0, bus_irq=0.
REQ-027 Reset during an access SHALL abort it; no ack is issued and no write is committed.

Configuration
REQ-028 Macro BUS_TIMER_PRESCALE_EN: defined = PRESC register and prescaler present per REQ-015/REQ-024.
- Undefined: offset 4 is reserved (reads 0, writes ignored).
- Undefined: every clock is a tick.

Structure
REQ-029 A shared package bus_timer_pkg SHALL hold register offsets, CTRL/STATUS bit positions and the PRESC width (8).
REQ-030 The prescaler SHALL be a sub-module bus_timer_prescaler (inputs clk, rst, presc, restart; output tick), instantiated only under BUS_TIMER_PRESCALE_EN.

Verification
REQ-031 Bench SHALL cover each scenario below.
- Read DIV after reset -> bus_ack high exactly in cycle 2 of the strobe, bus_dout=0x00000000.
- Write DIV=3, CTRL=0x7 (EN|IEN|AUTO), COUNT=3 -> EXP and bus_irq rise every 4 clocks; COUNT sequence 3,2,1,0,3.
- Write CTRL=0x1 (one-shot), COUNT=2 -> EXP=1 after 3 clocks; CTRL reads 0x0; COUNT stays 0.
- Write STATUS=1 in the expiry cycle -> EXP remains 1; the next STATUS=1 write clears it and bus_irq falls.
- With BUS_TIMER_PRESCALE_EN, PRESC=1, DIV=1, AUTO -> period 4 clocks; without the macro, offset 4 reads 0 after a write of 0xFF.
- Assert rst mid-write to DIV=0x55 -> no bus_ack; DIV reads 0 after reset.
